// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters: request handshake -> one EXEC cycle -> held response.
// Arbitration: ALU_ARB_ROUND_ROBIN_EN defined selects round-robin, otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  ReqValid,
  output logic [1:0]  ReqReady,
  input  logic [15:0] ReqA,
  input  logic [15:0] ReqB,
  input  logic [5:0]  ReqOpcode,
  input  logic [3:0]  ReqFunctionCode,
  output logic [1:0]  RespValid,
  input  logic [1:0]  RespReady,
  output logic [7:0]  RespO,
  output logic        RespOverflow,
  output logic        RespIllegal,
  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [2:0]  AluOpcode,
  output logic [1:0]  AluFunctionCode,
  output logic        AluEnable,
  input  logic [7:0]  AluO,
  input  logic        AluOverflow,
  output logic [1:0]  DbgState
);

  // Handshakes: a transfer happens on the rising edge where both valid and
  // ready of the same bit are high; valid never waits on ready.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [1:0] fc_q, fc_d;
  logic [7:0] o_q, o_d;
  logic       ovf_q, ovf_d;
  logic       ill_q, ill_d;

  logic       win;
  logic       in_idle;
  logic       in_exec;
  logic       in_resp;
  logic       req_fire;
  logic       resp_fire;
  logic       op_legal;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic [2:0] sel_op;
  logic [1:0] sel_fc;

  assign in_idle = (state_q == ST_IDLE);
  assign in_exec = (state_q == ST_EXEC);
  assign in_resp = (state_q == ST_RESP);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // On a tie the pointer decides; a lone requester always wins.
  always_comb begin
    win = (ReqValid == 2'b11) ? ptr_q : ReqValid[1];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (resp_fire) begin
      ptr_d = ~grant_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win = ~ReqValid[0];
  end
`endif

  always_comb begin
    ReqReady = 2'b00;
    if (in_idle && !Reset && (ReqValid != 2'b00)) begin
      ReqReady = win ? 2'b10 : 2'b01;
    end
  end

  assign req_fire  = (ReqValid & ReqReady) != 2'b00;
  assign resp_fire = in_resp && RespReady[grant_q];
  assign op_legal  = (op_q[2:1] == 2'b00);

  assign sel_a  = win ? ReqA[15:8] : ReqA[7:0];
  assign sel_b  = win ? ReqB[15:8] : ReqB[7:0];
  assign sel_op = win ? ReqOpcode[5:3] : ReqOpcode[2:0];
  assign sel_fc = win ? ReqFunctionCode[3:2] : ReqFunctionCode[1:0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    fc_d    = fc_q;
    o_d     = o_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          grant_d = win;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          fc_d    = sel_fc;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Unknown opcodes never trust the ALU outputs.
        o_d     = op_legal ? AluO : 8'h00;
        ovf_d   = op_legal ? AluOverflow : 1'b0;
        ill_d   = ~op_legal;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      fc_q    <= 2'b00;
      o_q     <= 8'h00;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      fc_q    <= fc_d;
      o_q     <= o_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  // The ALU only sees non-zero stimulus during its single execute cycle.
  assign AluEnable       = in_exec;
  assign AluA            = in_exec ? a_q  : 8'h00;
  assign AluB            = in_exec ? b_q  : 8'h00;
  assign AluOpcode       = in_exec ? op_q : 3'b000;
  assign AluFunctionCode = in_exec ? fc_q : 2'b00;

  always_comb begin
    RespValid = 2'b00;
    if (in_resp) begin
      RespValid = grant_q ? 2'b10 : 2'b01;
    end
  end

  assign RespO        = o_q;
  assign RespOverflow = ovf_q;
  assign RespIllegal  = ill_q;
  assign DbgState     = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 8-bit `alu` instance between two requesters. Each requester issues an operation (operands, Opcode, FunctionCode) over a valid/ready handshake, and gets back the registered result over a second valid/ready handshake. The block sits between the instruction-issue logic and the ALU. It owns the ALU's `Enable`, so the ALU is driven only while an operation is executing.

## Interface

Parameters:
- none; widths are fixed to the 8-bit ALU.

Ports (vector bit i belongs to requester i; packed buses are {req1, req0}):
- Clk  input  1  sole clock, rising edge
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  2  requester i presents an operation
- ReqReady  output  2  operation of requester i accepted this cycle
- ReqA  input  16  operand A per requester
- ReqB  input  16  operand B per requester
- ReqOpcode  input  6  3-bit Opcode per requester
- ReqFunctionCode  input  4  2-bit FunctionCode per requester
- RespValid  output  2  result available for requester i
- RespReady  input  2  requester i consumes the result
- RespO  output  8  result byte, shared, valid for the RespValid bit that is set
- RespOverflow  output  1  carry/overflow bit of the result
- RespIllegal  output  1  the Opcode was not 000 or 001
- AluA, AluB  output  8  ALU operands
- AluOpcode  output  3  ALU Opcode
- AluFunctionCode  output  2  ALU FunctionCode
- AluEnable  output  1  ALU Enable
- AluO  input  8  ALU result
- AluOverflow  input  1  ALU Overflow

## Operation

The FSM has three states: IDLE, EXEC, RESP.

IDLE:
- If no ReqValid bit is set, stay in IDLE.
- Otherwise select a winner g; ReqReady[g] is combinational from ReqValid and the pointer, and only one bit is ever set.
- On the handshake, capture the winner's A, B, Opcode and FunctionCode, record g, and go to EXEC.

EXEC (exactly one cycle):
- AluEnable=1 and Alu* are driven from the captured registers.
- At the clock edge, capture AluO and AluOverflow into the result registers, then go to RESP.
- For Opcode not in {000, 001}, ignore the ALU outputs: capture O=0, Overflow=0 and set RespIllegal=1.

RESP:
- RespValid[g]=1; RespO, RespOverflow and RespIllegal are held stable.
- When RespReady[g]=1, clear RespValid, set the priority pointer to favour the other requester (1-g), and go to IDLE.
- RespReady on the non-granted bit is ignored.

General rules:
- ReqReady is 0 in EXEC and RESP. A pending request simply waits; it is never dropped.
- Outside EXEC: AluEnable=0 and AluA, AluB, AluOpcode, AluFunctionCode are all 0.
- Results are passed through bit-exact from the ALU. Opcode 000 with FunctionCode 1x yields whatever the ALU gives (0/0).

## Timing

- Reset, synchronous: state=IDLE, pointer=0, ReqReady=0, RespValid=0, RespO=0, RespOverflow=0, RespIllegal=0, AluEnable=0, all Alu* outputs 0.
- Reset mid-operation, in EXEC or RESP: the operation is discarded and no response is given.
- Latency:
  - Request accepted at edge T.
  - EXEC during cycle T+1.
  - RespValid high from cycle T+2.
  - Minimum 3 cycles per operation with RespReady held high.
- Back-to-back: the cycle after the RESP handshake is IDLE, so the next grant can occur in that cycle.
- Simultaneous ReqValid=2'b11 in IDLE: the grant goes to the pointer's requester.
- ReqValid dropping before the handshake is legal; nothing is captured.

## Configuration

The arbitration policy is selected by the macro `ALU_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin as described; the pointer toggles after each completed response.
- Undefined: fixed priority, requester 0 always wins a tie, and the pointer logic is removed. A continuously valid requester 0 may starve requester 1; this is accepted.

## Test plan

1. Requester 0, Opcode 000, FunctionCode 00, A=0xF0, B=0x20, RespReady=1 -> RespValid[0] at T+2, RespO=0x10, RespOverflow=1, RespIllegal=0; AluEnable high only during T+1.
2. Requester 1, Opcode 000, FunctionCode 01, A=0x05, B=0x03 -> RespValid[1], RespO=0x02, RespOverflow=1.
3. Requester 0, Opcode 001, FunctionCode 11, A=0x5A -> RespO=0xA5, RespOverflow=0. Then Opcode 101 -> RespO=0x00, RespOverflow=0, RespIllegal=1.
4. Both ReqValid held high for 4 operations, with the macro defined -> grants go 0,1,0,1. With the macro undefined -> 0,0,0,0.
5. Hold RespReady[0]=0 for 5 cycles with ReqValid[1]=1 -> RespValid[0] and RespO stay stable, ReqReady=2'b00 throughout. After RespReady[0] rises, requester 1 is granted on the next cycle.
6. Assert Reset during EXEC -> next cycle all outputs 0 and state IDLE, no RespValid ever for that operation; the re-issued request completes normally.
